mmio_bus_fabric: RTL and testbench
==================================

Name: mmio_bus_fabric

Overview:
- Parametrised memory-mapped bus fabric between the riscv64 core data port and N peripheral slaves (RAM, keyboard, UART, SD bridge, ...).
- Replaces ad-hoc per-device address compares and done flags with one decoder, one transaction FSM and uniform done/error signalling.
- Adds per-slave wait states, a timeout, unmapped-address errors and write-completion handshake; runs on the single system clock.

Parameters:
- ADDR_W, 64, master address width
- DATA_W, 64, data width
- NUM_SLAVES, 4, number of slave regions (1..16)
- BASE_ADDRS, {0x0000_9000, 0x0000_8010, 0x0000_8000, 0x0000_0000}, packed NUM_SLAVES*ADDR_W region bases; slave i uses slice [i*ADDR_W +: ADDR_W]
- REGION_SIZES, {0x200, 0x8, 0x8, 0x3000}, packed NUM_SLAVES*ADDR_W region sizes in bytes, each nonzero
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before a timeout error (1..65535)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- bus_address  in  ADDR_W  master byte address
- bus_write_data  in  DATA_W  master write data
- bus_write_enable  in  1  write request, level, held until done
- bus_read_enable  in  1  read request, level, held until done
- bus_read_data  out  DATA_W  read response data
- bus_read_done  out  1  read complete
- bus_write_done  out  1  write complete
- bus_error  out  1  transaction ended in error; valid with done
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_offset  out  ADDR_W  address minus selected base
- s_write_data  out  DATA_W  latched write data
- s_write_enable  out  1  write strobe, exactly 1 cycle per transaction
- s_read_enable  out  1  read strobe, exactly 1 cycle per transaction
- s_read_data  in  NUM_SLAVES*DATA_W  per-slave read data
- s_ready  in  NUM_SLAVES  per-slave completion; read data valid when high
- err_addr  out  ADDR_W  last faulting address; ERR_LOG_EN only, else 0
- err_count  out  16  saturating error count; ERR_LOG_EN only, else 0

Behaviour:
- Reset values: FSM=IDLE; all outputs 0; latched address/data 0; timeout counter 0. Reset in any state aborts the transaction the same cycle; no strobe issues on the reset cycle.
- Decode: slave i hits when base_i <= addr < base_i+size_i, unsigned, computed at ADDR_W+1 bits so base+size does not wrap. On overlap the lowest index wins.
- IDLE: on read or write enable, latch address, write data, direction and decoded slave.
  - Unmapped address -> RESP with error.
  - Read and write both high -> RESP with error.
  - Otherwise -> ACCESS. The first ACCESS cycle drives s_sel plus a 1-cycle s_read_enable or s_write_enable.
- ACCESS: s_sel and s_offset are held stable.
  - When s_ready[sel] is high, capture s_read_data[sel] on reads, then go to RESP with no error. s_ready may be high in the strobe cycle itself, giving minimum latency: request cycle 0 -> done visible cycle 2.
  - The counter increments each ACCESS cycle. If it reaches TIMEOUT_CYCLES without s_ready -> RESP with error.
- RESP: assert bus_read_done or bus_write_done (matching the latched direction) and bus_error.
  - On error reads, bus_read_data = 0.
  - Done and data are held until both enables are low, then -> IDLE with done/error cleared.
  - A new request needs at least one cycle with both enables low, so no double issue.
- Changes to master address/data after latching are ignored until IDLE.
- A late s_ready from a timed-out slave is ignored.

Optional Feature:
- Macro MMIO_FABRIC_ERR_LOG_EN.
- Defined: on every entry to RESP with error, err_addr <= latched address and err_count increments, saturating at 0xFFFF. Both reset to 0.
- Undefined: err_addr and err_count are tied to 0; no log registers are synthesised.

Decomposition:
- Package mmio_pkg:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Error-cause codes: NONE, UNMAPPED, CONFLICT, TIMEOUT.
  - Default system base/size constants, shared with the top-level header defines.
- Sub-module mmio_addr_decode: purely combinational, address -> one-hot hit vector, hit flag, offset.
- Fabric: FSM, latches, timeout counter, response mux.

Test Plan:
1. RAM read: addr 0x100, slave0 s_ready in strobe cycle with data 0x1234 -> bus_read_done at cycle 2, data 0x1234, error 0; s_read_enable high exactly 1 cycle.
2. UART write: addr 0x8000, data 0x41, s_ready after 3 cycles -> s_sel=0b0010 one-hot, s_offset 0, a single s_write_enable pulse, bus_write_done high until write_enable drops.
3. Unmapped read: addr 0x5000 -> no strobe, bus_read_done and bus_error at cycle 1, data 0; with MMIO_FABRIC_ERR_LOG_EN, err_addr 0x5000 and err_count 1.
4. Timeout: TIMEOUT_CYCLES=4, slave3 addr 0x9004 never ready -> done and error after 4 ACCESS cycles; s_ready pulsed afterwards is ignored.
5. Conflict and boundary: read+write both high at 0x100 -> error, no strobe. Addr 0x2FFF hits slave0; 0x3000 is unmapped.
6. Reset during ACCESS with slave0 pending -> next cycle all outputs 0, FSM IDLE; a held enable then starts a fresh transaction.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared FSM/error encodings and the default system memory map
package mmio_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_UNMAPPED, ERR_CONFLICT, ERR_TIMEOUT} err_e;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_NUM_SLAVES = 4;
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_BASE_ADDRS =
    {64'h0000_9000, 64'h0000_8010, 64'h0000_8000, 64'h0000_0000};
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_REGION_SIZES =
    {64'h200, 64'h8, 64'h8, 64'h3000};
endpackage

// File: rtl/mmio_bus_fabric_if.sv
// mmio_bus_fabric_if: core-side bus, peripheral-side bus and error log signals
//   master: core/peripheral environment view; slave: fabric view
interface mmio_bus_fabric_if #(parameter int ADDR_W = 64, parameter int DATA_W = 64, parameter int NUM_SLAVES = 4);
  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_write_data;
  logic bus_write_enable;
  logic bus_read_enable;
  logic [DATA_W-1:0] bus_read_data;
  logic bus_read_done;
  logic bus_write_done;
  logic bus_error;
  logic [NUM_SLAVES-1:0] s_sel;
  logic [ADDR_W-1:0] s_offset;
  logic [DATA_W-1:0] s_write_data;
  logic s_write_enable;
  logic s_read_enable;
  logic [NUM_SLAVES*DATA_W-1:0] s_read_data;
  logic [NUM_SLAVES-1:0] s_ready;
  logic [ADDR_W-1:0] err_addr;
  logic [15:0] err_count;
  modport master (
    output bus_address, bus_write_data, bus_write_enable, bus_read_enable, s_read_data, s_ready,
    input bus_read_data, bus_read_done, bus_write_done, bus_error, s_sel, s_offset, s_write_data,
    input s_write_enable, s_read_enable, err_addr, err_count
  );
  modport slave (
    input bus_address, bus_write_data, bus_write_enable, bus_read_enable, s_read_data, s_ready,
    output bus_read_data, bus_read_done, bus_write_done, bus_error, s_sel, s_offset, s_write_data,
    output s_write_enable, s_read_enable, err_addr, err_count
  );
endinterface

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational address -> one-hot region hit, hit flag, region offset
//   addr_i: byte address; sel_o: one-hot hit (lowest index wins); hit_o: any hit; offset_o: addr - base
module mmio_addr_decode import mmio_pkg::*; #(
  parameter int ADDR_W = 64,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_SIZES = DEF_REGION_SIZES
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  hit_o,
  output logic [ADDR_W-1:0]     offset_o
);
  // Bounds use ADDR_W+1 bits so base+size cannot wrap; scanning downward lets the lowest index win.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    offset_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ({1'b0, addr_i} >= {1'b0, BASE_ADDRS[i*ADDR_W +: ADDR_W]} &&
          {1'b0, addr_i} < {1'b0, BASE_ADDRS[i*ADDR_W +: ADDR_W]} + {1'b0, REGION_SIZES[i*ADDR_W +: ADDR_W]}) begin
        sel_o = NUM_SLAVES'(1) << i;
        hit_o = 1'b1;
        offset_o = addr_i - BASE_ADDRS[i*ADDR_W +: ADDR_W];
      end
  end
endmodule

// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: core data port to NUM_SLAVES peripherals with decode, wait states, timeout and errors
//   clk, reset: system clock, synchronous active-high reset
//   bus (slave modport): bus_* master request/response, s_* peripheral strobes/data, err_addr/err_count
//   optional MMIO_FABRIC_ERR_LOG_EN: keeps last faulting address and a saturating error count
module mmio_bus_fabric import mmio_pkg::*; #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_SIZES = DEF_REGION_SIZES,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset,
  mmio_bus_fabric_if.slave bus
);
  state_e state_q, state_d;
  err_e cause_q, cause_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d, dec_sel;
  logic [ADDR_W-1:0] off_q, off_d, dec_off;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rdat;
  logic [15:0] cnt_q, cnt_d;
  logic dir_q, dir_d, dec_hit, rdy, rd, wr, access, strobe;
  assign rd = bus.bus_read_enable;
  assign wr = bus.bus_write_enable;
  mmio_addr_decode #(
    .ADDR_W(ADDR_W), .NUM_SLAVES(NUM_SLAVES), .BASE_ADDRS(BASE_ADDRS), .REGION_SIZES(REGION_SIZES)
  ) u_dec (
    .addr_i(bus.bus_address), .sel_o(dec_sel), .hit_o(dec_hit), .offset_o(dec_off)
  );
  always_comb begin
    rdy = 1'b0;
    rdat = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel_q[i]) begin
        rdy = bus.s_ready[i];
        rdat = bus.s_read_data[i*DATA_W +: DATA_W];
      end
  end
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    sel_d = sel_q;
    off_d = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && (rd || wr)) begin
      sel_d = dec_sel;
      off_d = dec_off;
      wdata_d = bus.bus_write_data;
      dir_d = wr && !rd;
      rdata_d = '0;
      cnt_d = '0;
      cause_d = (rd && wr) ? ERR_CONFLICT : !dec_hit ? ERR_UNMAPPED : ERR_NONE;
      state_d = (cause_d == ERR_NONE) ? ACCESS : RESP;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q + 16'd1;
      if (rdy) begin
        rdata_d = dir_q ? '0 : rdat;
        state_d = RESP;
      end else if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
        cause_d = ERR_TIMEOUT;
        state_d = RESP;
      end
    end else if (state_q == RESP && !rd && !wr) begin
      cause_d = ERR_NONE;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cause_q <= ERR_NONE;
      sel_q <= '0;
      off_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dir_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      sel_q <= sel_d;
      off_q <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
    end
  // Gating with reset keeps an aborted transaction from strobing during the reset cycle.
  assign access = state_q == ACCESS && !reset;
  assign strobe = access && cnt_q == '0;
  assign bus.s_sel = access ? sel_q : '0;
  assign bus.s_offset = off_q;
  assign bus.s_write_data = wdata_q;
  assign bus.s_write_enable = strobe && dir_q;
  assign bus.s_read_enable = strobe && !dir_q;
  assign bus.bus_read_done = state_q == RESP && !dir_q;
  assign bus.bus_write_done = state_q == RESP && dir_q;
  assign bus.bus_error = state_q == RESP && cause_q != ERR_NONE;
  assign bus.bus_read_data = bus.bus_read_done ? rdata_q : '0;
`ifdef MMIO_FABRIC_ERR_LOG_EN
  logic [ADDR_W-1:0] addr_q, err_addr_q;
  logic [15:0] err_count_q;
  always_ff @(posedge clk)
    if (reset) begin
      addr_q <= '0;
      err_addr_q <= '0;
      err_count_q <= '0;
    end else begin
      if (state_q == IDLE && (rd || wr)) addr_q <= bus.bus_address;
      if (state_d == RESP && state_q != RESP && cause_d != ERR_NONE) begin
        err_addr_q <= (state_q == IDLE) ? bus.bus_address : addr_q;
        err_count_q <= err_count_q + 16'(err_count_q != 16'hFFFF);
      end
    end
  assign bus.err_addr = err_addr_q;
  assign bus.err_count = err_count_q;
`else
  assign bus.err_addr = '0;
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_mmio_bus_fabric.sv
// tb_mmio_bus_fabric: table-driven and randomized self-checking bench for mmio_bus_fabric
module tb_mmio_bus_fabric;
  localparam int T = 4;
  typedef struct {
    logic [63:0] addr;
    logic we, re;
    logic [63:0] wdata;
    int lat;
    logic [63:0] sdata;
    logic e_err;
    int e_cyc;
    logic [3:0] e_sel;
    logic [63:0] e_off;
    int e_str;
    logic [63:0] e_rdata;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0, n_pass = 0;
  int o_cyc, o_str;
  logic o_err, o_rd, o_wr, o_selbad, o_hold, o_clear;
  logic [3:0] o_sel;
  logic [63:0] o_off, o_wdata, o_rdata;
  logic [63:0] base [4] = '{64'h0, 64'h8000, 64'h8010, 64'h9000};
  logic [63:0] size [4] = '{64'h3000, 64'h8, 64'h8, 64'h200};
  logic [15:0] log_n = 16'd0;
  logic [63:0] log_addr = 64'd0;
  vec_t tab [13];
  always #5 clk = ~clk;
  mmio_bus_fabric_if #(.ADDR_W(64), .DATA_W(64), .NUM_SLAVES(4)) bus ();
  mmio_bus_fabric #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic vec_t mk(input logic [63:0] a, input logic w, input logic r, input logic [63:0] wd,
                              input int lat, input logic [63:0] sd, input logic ee, input int ec,
                              input logic [3:0] es, input logic [63:0] eo, input int est, input logic [63:0] er);
    vec_t v;
    v.addr = a; v.we = w; v.re = r; v.wdata = wd; v.lat = lat; v.sdata = sd;
    v.e_err = ee; v.e_cyc = ec; v.e_sel = es; v.e_off = eo; v.e_str = est; v.e_rdata = er;
    return v;
  endfunction
  // Reference model: region lookup by distance from base, timing from latency vs timeout budget.
  function automatic vec_t model(input vec_t v);
    int idx = -1;
    logic early;
    for (int i = 0; i < 4; i++)
      if (idx < 0 && v.addr >= base[i] && v.addr - base[i] < size[i]) idx = i;
    early = (v.we && v.re) || idx < 0;
    v.e_err = early || v.lat >= T;
    v.e_cyc = early ? 1 : (v.lat < T ? v.lat + 2 : T + 1);
    v.e_str = early ? 0 : 1;
    v.e_sel = early ? 4'd0 : 4'(1 << idx);
    v.e_off = early ? 64'd0 : v.addr - base[idx];
    v.e_rdata = (!v.we && !v.e_err) ? v.sdata + 64'(idx) : 64'd0;
    return v;
  endfunction
  task automatic run(input vec_t v);
    int sc = -1;
    bus.bus_address = v.addr;
    bus.bus_write_data = v.wdata;
    bus.bus_write_enable = v.we;
    bus.bus_read_enable = v.re;
    for (int i = 0; i < 4; i++) bus.s_read_data[i*64 +: 64] = v.sdata + 64'(i);
    bus.s_ready = '0;
    o_cyc = -1; o_str = 0; o_sel = '0; o_off = '0; o_wdata = '0; o_selbad = 1'b0;
    o_err = 1'b0; o_rd = 1'b0; o_wr = 1'b0; o_rdata = '0;
    for (int c = 1; c <= 40 && o_cyc < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.s_ready = '0;
      if (bus.s_read_enable || bus.s_write_enable) begin
        o_str++;
        if (sc < 0) begin
          sc = c; o_sel = bus.s_sel; o_off = bus.s_offset; o_wdata = bus.s_write_data;
        end
      end
      if (sc >= 0 && bus.s_sel != 0 && bus.s_sel != o_sel) o_selbad = 1'b1;
      if (bus.bus_read_done || bus.bus_write_done) begin
        o_cyc = c; o_err = bus.bus_error; o_rd = bus.bus_read_done; o_wr = bus.bus_write_done;
        o_rdata = bus.bus_read_data;
      end else if (sc >= 0 && c - sc == v.lat) bus.s_ready = o_sel;
    end
    o_hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.s_ready = '1;
      @(posedge clk);
      @(negedge clk);
      if (bus.bus_read_done !== o_rd || bus.bus_write_done !== o_wr || bus.bus_error !== o_err ||
          bus.bus_read_data !== o_rdata || bus.s_read_enable || bus.s_write_enable) o_hold = 1'b0;
    end
    bus.s_ready = '0;
    bus.bus_read_enable = 1'b0;
    bus.bus_write_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o_clear = !bus.bus_read_done && !bus.bus_write_done && !bus.bus_error;
  endtask
  task automatic check_vec(input vec_t v, input string tag);
    run(v);
    chk({tag, " done_cycle"}, 64'(o_cyc), 64'(v.e_cyc));
    chk({tag, " error"}, 64'(o_err), 64'(v.e_err));
    chk({tag, " done_kind"}, {62'd0, o_rd, o_wr}, {62'd0, !(v.we && !v.re), v.we && !v.re});
    chk({tag, " strobes"}, 64'(o_str), 64'(v.e_str));
    chk({tag, " sel"}, 64'(o_sel), 64'(v.e_sel));
    chk({tag, " offset"}, o_off, v.e_off);
    chk({tag, " sel_stable"}, 64'(o_selbad), 64'd0);
    chk({tag, " hold"}, 64'(o_hold), 64'd1);
    chk({tag, " clear"}, 64'(o_clear), 64'd1);
    if (!v.we) chk({tag, " rdata"}, o_rdata, v.e_rdata);
    if (v.we && !v.re && v.e_str == 1) chk({tag, " wdata"}, o_wdata, v.wdata);
    if (v.e_err) begin
      log_addr = v.addr;
      if (log_n != 16'hFFFF) log_n++;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t v;
    tab[0]  = mk(64'h100,  0, 1, 64'h0,    0,  64'h1234, 0, 2, 4'b0001, 64'h100,  1, 64'h1234);
    tab[1]  = mk(64'h8000, 1, 0, 64'h41,   3,  64'h0,    0, 5, 4'b0010, 64'h0,    1, 64'h0);
    tab[2]  = mk(64'h5000, 0, 1, 64'h0,    0,  64'h77,   1, 1, 4'b0000, 64'h0,    0, 64'h0);
    tab[3]  = mk(64'h9004, 0, 1, 64'h0,    99, 64'h77,   1, 5, 4'b1000, 64'h4,    1, 64'h0);
    tab[4]  = mk(64'h100,  1, 1, 64'h9,    0,  64'h77,   1, 1, 4'b0000, 64'h0,    0, 64'h0);
    tab[5]  = mk(64'h2FFF, 0, 1, 64'h0,    1,  64'hAA,   0, 3, 4'b0001, 64'h2FFF, 1, 64'hAA);
    tab[6]  = mk(64'h3000, 0, 1, 64'h0,    0,  64'h0,    1, 1, 4'b0000, 64'h0,    0, 64'h0);
    tab[7]  = mk(64'h8017, 1, 0, 64'hDEAD, 0,  64'h0,    0, 2, 4'b0100, 64'h7,    1, 64'h0);
    tab[8]  = mk(64'h8018, 0, 1, 64'h0,    0,  64'h0,    1, 1, 4'b0000, 64'h0,    0, 64'h0);
    tab[9]  = mk(64'h91FF, 0, 1, 64'h0,    3,  64'h55,   0, 5, 4'b1000, 64'h1FF,  1, 64'h58);
    tab[10] = mk(64'h9200, 1, 0, 64'h5,    0,  64'h0,    1, 1, 4'b0000, 64'h0,    0, 64'h0);
    tab[11] = mk(64'h9000, 0, 1, 64'h0,    4,  64'h66,   1, 5, 4'b1000, 64'h0,    1, 64'h0);
    tab[12] = mk(64'h8008, 0, 1, 64'h0,    0,  64'h0,    1, 1, 4'b0000, 64'h0,    0, 64'h0);
    bus.bus_address = '0; bus.bus_write_data = '0; bus.bus_write_enable = 1'b0; bus.bus_read_enable = 1'b0;
    bus.s_read_data = '0; bus.s_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset done", {62'd0, bus.bus_read_done, bus.bus_write_done}, 64'd0);
    chk("reset error", 64'(bus.bus_error), 64'd0);
    chk("reset sel", 64'(bus.s_sel), 64'd0);
    chk("reset strobes", {62'd0, bus.s_read_enable, bus.s_write_enable}, 64'd0);
    chk("reset offset", bus.s_offset, 64'd0);
    chk("reset err_count", 64'(bus.err_count), 64'd0);
    for (int i = 0; i < 13; i++) check_vec(tab[i], $sformatf("row%0d", i));
    for (int n = 0; n < 60; n++) begin
      int k = $urandom_range(0, 9);
      int s = $urandom_range(0, 3);
      int m = $urandom_range(0, 9);
      v.addr = (k < 8) ? base[s] + 64'($urandom_range(0, 32'(size[s]) + 3)) : 64'($urandom_range(0, 32'hA000));
      v.we = (m == 0) || (m >= 5);
      v.re = (m < 5);
      v.wdata = {$urandom, $urandom};
      v.sdata = {$urandom, $urandom};
      v.lat = $urandom_range(0, 6);
      check_vec(model(v), $sformatf("rand%0d", n));
    end
`ifdef MMIO_FABRIC_ERR_LOG_EN
    chk("log count", 64'(bus.err_count), 64'(log_n));
    chk("log addr", bus.err_addr, log_addr);
`else
    chk("log count", 64'(bus.err_count), 64'd0);
    chk("log addr", bus.err_addr, 64'd0);
`endif
    bus.bus_address = 64'h100; bus.bus_write_data = 64'h77; bus.bus_read_enable = 1'b1; bus.s_ready = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst pre strobe", 64'(bus.s_read_enable), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst strobe kill", {62'd0, bus.s_read_enable, bus.s_write_enable}, 64'd0);
    chk("rst sel kill", 64'(bus.s_sel), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst idle sel", 64'(bus.s_sel), 64'd0);
    chk("rst idle offset", bus.s_offset, 64'd0);
    chk("rst idle wdata", bus.s_write_data, 64'd0);
    chk("rst idle strobes", {62'd0, bus.s_read_enable, bus.s_write_enable}, 64'd0);
    chk("rst idle done", {61'd0, bus.bus_read_done, bus.bus_write_done, bus.bus_error}, 64'd0);
    chk("rst idle rdata", bus.bus_read_data, 64'd0);
    chk("rst idle err_count", 64'(bus.err_count), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst fresh strobe", 64'(bus.s_read_enable), 64'd1);
    chk("rst fresh sel", 64'(bus.s_sel), 64'd1);
    chk("rst fresh offset", bus.s_offset, 64'h100);
    bus.s_read_data[63:0] = 64'hBEEF;
    bus.s_ready = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    bus.s_ready = '0;
    chk("rst fresh done", {62'd0, bus.bus_read_done, bus.bus_error}, 64'd2);
    chk("rst fresh rdata", bus.bus_read_data, 64'hBEEF);
    bus.bus_read_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst fresh clear", 64'(bus.bus_read_done), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
